// File: rtl/fp_32_to_8_converter.sv
// FP32 -> FP8 E5M2 narrowing converter: two-stage valid/ready pipeline, RNE rounding, saturating
// overflow/underflow event counters. Define FP8_SATURATE_EN to clamp finite overflow to max finite.
module fp_32_to_8_converter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 input_valid,
    output logic                 input_ready,
    input  logic [31:0]          fp_data_in,
    output logic                 output_valid,
    input  logic                 output_ready,
    output logic [7:0]           fp_data_out,
    output logic                 nan_num,
    output logic                 infinity,
    input  logic                 clear_cnt,
    output logic [CNT_WIDTH-1:0] overflow_cnt,
    output logic [CNT_WIDTH-1:0] underflow_cnt
);

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [1:0] man;
        logic       guard;
        logic       sticky;
        logic       is_nan;
        logic       is_inf;
        logic       is_ovf;
        logic       nonzero;
    } s1_t;

    s1_t                  s1_d, s1_q;
    logic                 s1_valid_q, s2_valid_q;
    logic                 s1_adv_s, s2_adv_s, out_fire_s;
    logic [7:0]           exp_in_s, shamt_s;
    logic [22:0]          frac_s;
    logic [4:0]           nexp_s;
    logic [49:0]          ext_s;
    logic [48:0]          shifted_s;
    logic                 round_up_s;
    logic [6:0]           mag_s;
    logic [7:0]           out_d, out_q;
    logic                 nan_d, nan_q, inf_d, inf_q;
    logic                 ovf_d, ovf_q, unf_d, unf_q;
    logic [CNT_WIDTH-1:0] ovf_cnt_d, ovf_cnt_q, unf_cnt_d, unf_cnt_q;

    assign s2_adv_s      = !s2_valid_q || output_ready;
    assign s1_adv_s      = !s1_valid_q || s2_adv_s;
    assign input_ready   = s1_adv_s;
    assign out_fire_s    = s2_valid_q && output_ready;
    assign output_valid  = s2_valid_q;
    assign fp_data_out   = out_q;
    assign nan_num       = nan_q;
    assign infinity      = inf_q;
    assign overflow_cnt  = ovf_cnt_q;
    assign underflow_cnt = unf_cnt_q;

    assign exp_in_s  = fp_data_in[30:23];
    assign frac_s    = fp_data_in[22:0];
    // Rebias 127 -> 15 is a subtraction of 112, i.e. 16 modulo the 5-bit field.
    assign nexp_s    = exp_in_s[4:0] - 5'd16;
    assign shamt_s   = 8'd113 - exp_in_s;
    assign ext_s     = {1'b1, frac_s, 26'd0};
    assign shifted_s = 49'(ext_s >> shamt_s);

    // Stage 1: classify the operand and align its significand to the E5M2 grid.
    always_comb begin
        s1_d      = '0;
        s1_d.sign = fp_data_in[31];
        if (exp_in_s == 8'hFF) begin
            s1_d.is_nan = (frac_s != 23'd0);
            s1_d.is_inf = (frac_s == 23'd0);
        end else if (exp_in_s == 8'h00) begin
            s1_d.nonzero = (frac_s != 23'd0);
        end else if (exp_in_s >= 8'd143) begin
            s1_d.is_ovf = 1'b1;
        end else if (exp_in_s >= 8'd113) begin
            s1_d.exp     = nexp_s;
            s1_d.man     = frac_s[22:21];
            s1_d.guard   = frac_s[20];
            s1_d.sticky  = |frac_s[19:0];
            s1_d.nonzero = 1'b1;
        end else begin
            s1_d.nonzero = 1'b1;
            if (shamt_s > 8'd26) begin
                s1_d.sticky = 1'b1;
            end else begin
                s1_d.man    = shifted_s[48:47];
                s1_d.guard  = shifted_s[46];
                s1_d.sticky = |shifted_s[45:0];
            end
        end
    end

    // Stage 1 register: advances whenever stage 2 can take its current content.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (s1_adv_s) begin
            s1_valid_q <= input_valid;
            if (input_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // A mantissa carry ripples into the exponent; a subnormal 3+1 lands on 0x04 naturally.
    assign round_up_s = s1_q.guard && (s1_q.sticky || s1_q.man[0]);
    assign mag_s      = {s1_q.exp, s1_q.man} + {6'd0, round_up_s};

    // Stage 2: pick the packed result and the event raised by this conversion.
    always_comb begin
        out_d = {s1_q.sign, mag_s};
        nan_d = 1'b0;
        inf_d = 1'b0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (s1_q.is_nan) begin
            out_d = {s1_q.sign, 7'h7F};
            nan_d = 1'b1;
        end else if (s1_q.is_inf) begin
            out_d = {s1_q.sign, 7'h7C};
            inf_d = 1'b1;
        end else if (s1_q.is_ovf || (mag_s[6:2] == 5'd31)) begin
            ovf_d = 1'b1;
`ifdef FP8_SATURATE_EN
            out_d = {s1_q.sign, 7'h7B};
`else
            out_d = {s1_q.sign, 7'h7C};
            inf_d = 1'b1;
`endif
        end else begin
            unf_d = s1_q.nonzero && (mag_s == 7'd0);
        end
    end

    // Output registers: hold while the consumer stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid_q <= 1'b0;
            out_q      <= 8'd0;
            nan_q      <= 1'b0;
            inf_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_q <= out_d;
                nan_q <= nan_d;
                inf_q <= inf_d;
                ovf_q <= ovf_d;
                unf_q <= unf_d;
            end
        end
    end

    // Event counters: count on the output handshake, saturate, clear wins.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        unf_cnt_d = unf_cnt_q;
        if (clear_cnt) begin
            ovf_cnt_d = {CNT_WIDTH{1'b0}};
            unf_cnt_d = {CNT_WIDTH{1'b0}};
        end else begin
            if (out_fire_s && ovf_q && (ovf_cnt_q != {CNT_WIDTH{1'b1}})) begin
                ovf_cnt_d = ovf_cnt_q + CNT_WIDTH'(1);
            end else begin
                ovf_cnt_d = ovf_cnt_q;
            end
            if (out_fire_s && unf_q && (unf_cnt_q != {CNT_WIDTH{1'b1}})) begin
                unf_cnt_d = unf_cnt_q + CNT_WIDTH'(1);
            end else begin
                unf_cnt_d = unf_cnt_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_cnt_q <= {CNT_WIDTH{1'b0}};
            unf_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            unf_cnt_q <= unf_cnt_d;
        end
    end

endmodule

// File: tb/tb_fp_32_to_8_converter.sv
// Self-checking bench for fp_32_to_8_converter: table-driven scoreboard, backpressure,
// counter clear/saturation and mid-flight reset scenarios.
module tb_fp_32_to_8_converter;

    localparam int CW = 3;
    localparam int NV = 20;
`ifdef FP8_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [6:0] OVF_MAG7 = SAT ? 7'h7B : 7'h7C;
    localparam logic [2:0] K_NUM = 3'd0, K_NAN = 3'd1, K_INF = 3'd2, K_OVF = 3'd3, K_UNF = 3'd4;

    typedef struct packed {
        logic [31:0] in;
        logic [7:0]  out;
        logic [2:0]  kind;
    } vec_t;

    typedef struct packed {
        logic [31:0] in;
        logic [7:0]  data;
        logic        nan;
        logic        inf;
        logic        ovf;
        logic        unf;
    } sb_t;

    logic          clk, rstn, input_valid, input_ready, output_valid, output_ready;
    logic          nan_num, infinity, clear_cnt;
    logic [31:0]   fp_data_in;
    logic [7:0]    fp_data_out;
    logic [CW-1:0] overflow_cnt, underflow_cnt;

    int  checks = 0;
    int  passed = 0;
    int  exp_ovf = 0;
    int  exp_unf = 0;
    sb_t sb_q[$];

    // Overflow rows list the default-build value; the expectation is derived from SAT below.
    vec_t vecs [NV] = '{
        '{32'h3F800000, 8'h3C, K_NUM}, '{32'hC0000000, 8'hC0, K_NUM},
        '{32'h00000000, 8'h00, K_NUM}, '{32'h80000000, 8'h80, K_NUM},
        '{32'h3FB00000, 8'h3E, K_NUM}, '{32'h3F900000, 8'h3C, K_NUM},
        '{32'h3F900001, 8'h3D, K_NUM}, '{32'h47800000, 8'h7C, K_OVF},
        '{32'h47700000, 8'h7C, K_OVF}, '{32'hC7800000, 8'hFC, K_OVF},
        '{32'h47600000, 8'h7B, K_NUM}, '{32'h37800000, 8'h01, K_NUM},
        '{32'hB7000000, 8'h80, K_UNF}, '{32'h387FFFFF, 8'h04, K_NUM},
        '{32'h38000000, 8'h02, K_NUM}, '{32'h00000001, 8'h00, K_UNF},
        '{32'h33800000, 8'h00, K_UNF}, '{32'h00800000, 8'h00, K_UNF},
        '{32'h7FC00000, 8'h7F, K_NAN}, '{32'hFF800000, 8'hFC, K_INF}
    };

    fp_32_to_8_converter #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rstn(rstn),
        .input_valid(input_valid), .input_ready(input_ready), .fp_data_in(fp_data_in),
        .output_valid(output_valid), .output_ready(output_ready), .fp_data_out(fp_data_out),
        .nan_num(nan_num), .infinity(infinity), .clear_cnt(clear_cnt),
        .overflow_cnt(overflow_cnt), .underflow_cnt(underflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic sb_t expect_of(input vec_t v);
        sb_t e;
        e.in   = v.in;
        e.data = (v.kind == K_OVF) ? {v.in[31], OVF_MAG7} : v.out;
        e.nan  = (v.kind == K_NAN);
        e.inf  = (v.kind == K_INF) || ((v.kind == K_OVF) && !SAT);
        e.ovf  = (v.kind == K_OVF);
        e.unf  = (v.kind == K_UNF);
        return e;
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= (1 << CW) - 1) ? c : c + 1;
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (output_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", output_valid); else passed++;
        checks++; if (fp_data_out !== 8'h00) $display("FAIL rst_data got=%h exp=00", fp_data_out); else passed++;
        checks++; if ({nan_num, infinity} !== 2'b00) $display("FAIL rst_flags got=%b%b exp=00", nan_num, infinity); else passed++;
        checks++; if (overflow_cnt !== '0) $display("FAIL rst_ovf_cnt got=%0d exp=0", overflow_cnt); else passed++;
        checks++; if (underflow_cnt !== '0) $display("FAIL rst_unf_cnt got=%0d exp=0", underflow_cnt); else passed++;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (input_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", input_ready); else passed++;
    endtask

    task automatic test_conversions();
        int  sent = 0;
        int  got  = 0;
        int  cyc  = 0;
        sb_t e;
        while (got < NV && cyc < 400) begin
            input_valid  = (sent < NV);
            fp_data_in   = (sent < NV) ? vecs[sent].in : 32'h0;
            output_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (input_valid && input_ready) begin
                sb_q.push_back(expect_of(vecs[sent]));
                sent++;
            end
            if (output_valid && output_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL conv_extra got=%h exp=no_output", fp_data_out);
                end else begin
                    e = sb_q.pop_front();
                    if ({fp_data_out, nan_num, infinity} !== {e.data, e.nan, e.inf})
                        $display("FAIL conv in=%h got=%h nan=%b inf=%b exp=%h nan=%b inf=%b",
                                 e.in, fp_data_out, nan_num, infinity, e.data, e.nan, e.inf);
                    else passed++;
                    if (e.ovf) exp_ovf = sat_inc(exp_ovf);
                    if (e.unf) exp_unf = sat_inc(exp_unf);
                end
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        input_valid = 1'b0;
        if (got < NV) begin
            checks++;
            $display("FAIL conv_timeout got=%0d exp=%0d outputs", got, NV);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (overflow_cnt !== CW'(exp_ovf)) $display("FAIL conv_ovf_cnt got=%0d exp=%0d", overflow_cnt, exp_ovf); else passed++;
        checks++; if (underflow_cnt !== CW'(exp_unf)) $display("FAIL conv_unf_cnt got=%0d exp=%0d", underflow_cnt, exp_unf); else passed++;
    endtask

    task automatic test_back_to_back();
        int         idx [4] = '{0, 1, 6, 14};
        int         sent = 0;
        int         got  = 0;
        int         cyc  = 0;
        logic [9:0] held = '0;
        bit         held_v = 1'b0;
        sb_t        e;
        while (got < 4 && cyc < 60) begin
            input_valid  = (sent < 4);
            fp_data_in   = (sent < 4) ? vecs[idx[sent]].in : 32'h0;
            output_ready = (cyc >= 5);
            @(negedge clk);
            if (cyc == 4) begin
                checks++;
                if (sent !== 2 || input_ready !== 1'b0)
                    $display("FAIL bp_accepts got=%0d ready=%b exp=2 ready=0", sent, input_ready);
                else passed++;
            end
            if (output_valid && !output_ready) begin
                if (held_v) begin
                    checks++;
                    if ({fp_data_out, nan_num, infinity} !== held)
                        $display("FAIL bp_hold got=%h exp=%h", {fp_data_out, nan_num, infinity}, held);
                    else passed++;
                end
                held   = {fp_data_out, nan_num, infinity};
                held_v = 1'b1;
            end
            if (input_valid && input_ready) begin
                sb_q.push_back(expect_of(vecs[idx[sent]]));
                sent++;
            end
            if (output_valid && output_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL bp_extra got=%h exp=no_output", fp_data_out);
                end else begin
                    e = sb_q.pop_front();
                    if ({fp_data_out, nan_num, infinity} !== {e.data, e.nan, e.inf})
                        $display("FAIL bp_order in=%h got=%h exp=%h", e.in, fp_data_out, e.data);
                    else passed++;
                end
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        input_valid = 1'b0;
        if (got < 4) begin
            checks++;
            $display("FAIL bp_timeout got=%0d exp=4 outputs", got);
        end
    endtask

    task automatic test_clear();
        clear_cnt = 1'b1;
        @(posedge clk);
        #1;
        clear_cnt = 1'b0;
        exp_ovf = 0;
        exp_unf = 0;
        checks++; if ({overflow_cnt, underflow_cnt} !== '0) $display("FAIL clr got=%0d/%0d exp=0/0", overflow_cnt, underflow_cnt); else passed++;
        // Park an overflow at the output, then clear in the same cycle as its handshake.
        output_ready = 1'b0;
        input_valid  = 1'b1;
        fp_data_in   = 32'h47800000;
        @(posedge clk);
        #1;
        input_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (output_valid !== 1'b1) $display("FAIL clr_park got=%b exp=1", output_valid); else passed++;
        output_ready = 1'b1;
        clear_cnt    = 1'b1;
        @(posedge clk);
        #1;
        clear_cnt = 1'b0;
        checks++; if (overflow_cnt !== '0) $display("FAIL clr_priority got=%0d exp=0", overflow_cnt); else passed++;
        input_valid = 1'b1;
        @(posedge clk);
        #1;
        input_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_ovf = 1;
        checks++; if (overflow_cnt !== CW'(exp_ovf)) $display("FAIL clr_count got=%0d exp=%0d", overflow_cnt, exp_ovf); else passed++;
    endtask

    task automatic test_saturation();
        output_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            input_valid = 1'b1;
            fp_data_in  = (i < 10) ? 32'hC7800000 : 32'h80000001;
            if (i < 10) exp_ovf = sat_inc(exp_ovf);
            else exp_unf = sat_inc(exp_unf);
            @(posedge clk);
            #1;
        end
        input_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (overflow_cnt !== CW'(exp_ovf)) $display("FAIL sat_ovf got=%0d exp=%0d", overflow_cnt, exp_ovf); else passed++;
        checks++; if (underflow_cnt !== CW'(exp_unf)) $display("FAIL sat_unf got=%0d exp=%0d", underflow_cnt, exp_unf); else passed++;
    endtask

    task automatic test_reset_midflight();
        bit seen = 1'b0;
        output_ready = 1'b0;
        input_valid  = 1'b1;
        fp_data_in   = 32'h3F800000;
        repeat (2) @(posedge clk);
        #1;
        input_valid = 1'b0;
        checks++; if (output_valid !== 1'b1) $display("FAIL mid_inflight got=%b exp=1", output_valid); else passed++;
        rstn         = 1'b0;
        output_ready = 1'b1;
        #1;
        exp_ovf = 0;
        exp_unf = 0;
        checks++; if (output_valid !== 1'b0) $display("FAIL mid_valid got=%b exp=0", output_valid); else passed++;
        checks++; if ({overflow_cnt, underflow_cnt} !== '0) $display("FAIL mid_cnt got=%0d/%0d exp=0/0", overflow_cnt, underflow_cnt); else passed++;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (output_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) $display("FAIL mid_drain got=1 exp=0 (stale output)"); else passed++;
    endtask

    initial begin
        rstn         = 1'b0;
        input_valid  = 1'b0;
        fp_data_in   = 32'h0;
        output_ready = 1'b0;
        clear_cnt    = 1'b0;
        test_reset();
        test_conversions();
        test_back_to_back();
        test_clear();
        test_saturation();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
